// File: rtl/eer_pkg.sv
// ============================================================================
// Module      : eer_pkg
// Description : Shared types for the CH beacon parser and knownCH selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eer_pkg;

    localparam int DEF_WORD_WIDTH = 16;

    typedef enum logic [DEF_WORD_WIDTH-1:0] {
        PKT_HB  = 16'h0001,
        PKT_CHA = 16'h0002
    } pkt_type_e;

    typedef struct packed {
        logic [DEF_WORD_WIDTH-1:0] CH_ID;
        logic [DEF_WORD_WIDTH-1:0] CH_Hops;
        logic [DEF_WORD_WIDTH-1:0] CH_QValue;
    } ch_info_t;

endpackage : eer_pkg

`default_nettype wire

// File: rtl/ch_beacon_parser.sv
// ============================================================================
// Module      : ch_beacon_parser
// Description : Fetches an 8-byte packet from receive memory and decodes
//               CHA / HB beacons for the knownCH selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ch_beacon_parser
    import eer_pkg::*;
#(
    parameter int MEM_DEPTH  = 2048,
    parameter int MEM_WIDTH  = 8,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_WIDTH-1:0]         my_ID,
    input  logic                          start,
    input  logic [$clog2(MEM_DEPTH)-1:0]  pkt_base,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
    input  logic [MEM_WIDTH-1:0]          mem_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pkt_err,
    output logic                          en_KCH,
    output logic [WORD_WIDTH-1:0]         fCH_ID,
    output logic [WORD_WIDTH-1:0]         fCH_Hops,
    output logic [WORD_WIDTH-1:0]         fCH_QValue,
    output logic                          HB_reset,
    output logic [WORD_WIDTH-1:0]         HB_CHlimit
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_DECODE = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic [2:0]                    cnt_q, cnt_d;
    logic [ADDR_W-1:0]             base_q, base_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic [3:0][WORD_WIDTH-1:0]    fields_q, fields_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          pkt_err_q, pkt_err_d;
    logic                          en_kch_q, en_kch_d;
    logic                          hb_reset_q, hb_reset_d;
    logic [WORD_WIDTH-1:0]         hb_limit_q, hb_limit_d;
    ch_info_t                      fch_q, fch_d;
    logic                          cap_en;
    logic [2:0]                    cap_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        fields_d   = fields_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pkt_err_d  = 1'b0;
        en_kch_d   = 1'b0;
        hb_reset_d = 1'b0;
        hb_limit_d = hb_limit_q;
        fch_d      = fch_q;
        cap_en     = 1'b0;
        cap_idx    = 3'd0;

        case (state_q)
            S_IDLE: begin
                // busy_q still high here means this is the done cycle; start is ignored.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    state_d    = S_FETCH;
                    cnt_d      = 3'd0;
                    base_d     = pkt_base;
                    mem_addr_d = pkt_base;
                    busy_d     = 1'b1;
                end
            end
            S_FETCH: begin
                // Read data lags the address by one cycle, so capture byte cnt-1.
                cap_en  = (cnt_q != 3'd0);
                cap_idx = cnt_q - 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                cap_en  = 1'b1;
                cap_idx = 3'd7;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (fields_q[0])
                    WORD_WIDTH'(PKT_CHA): begin
                        if (fields_q[1] != my_ID) begin
                            en_kch_d        = 1'b1;
                            fch_d.CH_ID     = fields_q[1];
                            fch_d.CH_QValue = fields_q[3];
                            fch_d.CH_Hops   = (&fields_q[2]) ? fields_q[2]
                                                             : fields_q[2] + WORD_WIDTH'(1);
                        end
                    end
                    WORD_WIDTH'(PKT_HB): begin
                        hb_reset_d = 1'b1;
                        hb_limit_d = fields_q[2];
                    end
                    default: pkt_err_d = 1'b1;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        // Even byte index is the MSB of its field (big-endian).
        if (cap_en) begin
            if (cap_idx[0] == 1'b0) begin
                fields_d[cap_idx[2:1]][WORD_WIDTH-1 -: MEM_WIDTH] = mem_rdata;
            end else begin
                fields_d[cap_idx[2:1]][MEM_WIDTH-1:0] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            base_q     <= '0;
            mem_addr_q <= '0;
            fields_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pkt_err_q  <= 1'b0;
            en_kch_q   <= 1'b0;
            hb_reset_q <= 1'b0;
            hb_limit_q <= '0;
            fch_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            fields_q   <= fields_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pkt_err_q  <= pkt_err_d;
            en_kch_q   <= en_kch_d;
            hb_reset_q <= hb_reset_d;
            hb_limit_q <= hb_limit_d;
            fch_q      <= fch_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pkt_err    = pkt_err_q;
    assign en_KCH     = en_kch_q;
    assign HB_reset   = hb_reset_q;
    assign HB_CHlimit = hb_limit_q;
    assign fCH_ID     = fch_q.CH_ID;
    assign fCH_Hops   = fch_q.CH_Hops;
    assign fCH_QValue = fch_q.CH_QValue;

endmodule : ch_beacon_parser

`default_nettype wire

// File: doc/ch_beacon_parser.md
Name: ch_beacon_parser

Overview:
- Upstream stage of the known-cluster-head selector (knownCH).
- Reads one received packet from the byte-wide receive packet memory and decodes it.
- For a cluster-head advertisement (CHA): drives that CH's ID, hop count and Q-value plus a one-cycle enable to knownCH.
- For a heartbeat (HB): updates the CH limit and pulses the HB reset that restarts knownCH collection.

Parameters:
- MEM_DEPTH, 2048, depth of the receive packet memory in bytes; address width = $clog2(MEM_DEPTH).
- MEM_WIDTH, 8, memory data width in bits.
- WORD_WIDTH, 16, packet field width; one field = 2 bytes, big-endian.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- my_ID  in  WORD_WIDTH  this node's ID.
- start  in  1  one-cycle request to parse the packet at pkt_base.
- pkt_base  in  $clog2(MEM_DEPTH)  byte address of packet byte 0.
- mem_addr  out  $clog2(MEM_DEPTH)  packet memory read address.
- mem_rdata  in  MEM_WIDTH  read data, valid 1 cycle after mem_addr.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the packet is finished.
- pkt_err  out  1  one-cycle pulse, with done, for an unknown type.
- en_KCH  out  1  one-cycle pulse: fCH_* hold a new CHA.
- fCH_ID, fCH_Hops, fCH_QValue  out  WORD_WIDTH each  latest accepted CHA fields.
- HB_reset  out  1  one-cycle pulse on a valid HB.
- HB_CHlimit  out  WORD_WIDTH  CH limit from the last HB.

Behaviour:
- Packet layout is 4 fields, 8 bytes, always fetched.
  - F0 = type: 0x0001 HB, 0x0002 CHA.
  - F1 = sender/CH ID.
  - F2 = HB: CH limit; CHA: hops.
  - F3 = CHA: Q-value; for HB, F3 is ignored.
- Reset: all outputs 0, state IDLE, field buffer cleared.
- FSM states and transitions:
  - IDLE: start=1 → FETCH, byte counter=0; otherwise stay. mem_addr holds its last value.
  - FETCH: mem_addr = (pkt_base latched + cnt) mod MEM_DEPTH, one byte per cycle, cnt 0..7. mem_rdata is captured one cycle later into field buffer byte cnt-1. After cnt=7 is issued → DRAIN (1 cycle to capture byte 7).
  - DRAIN → DECODE.
  - DECODE: evaluates type; next cycle → IDLE while the result pulses are asserted.
- Latency: start sampled at edge 0 → done (and any en_KCH/HB_reset/pkt_err) high in cycle 11, exactly one cycle.
- busy is high cycles 1..11.
- Decode rules, applied on the done cycle:
  - CHA with F1 != my_ID: fCH_ID=F1, fCH_QValue=F3, fCH_Hops=F2+1 saturating at 0xFFFF; en_KCH=1.
  - CHA with F1 == my_ID (own echo): no en_KCH, fCH_* unchanged, no error.
  - HB: HB_CHlimit=F2, HB_reset=1; fCH_* unchanged.
  - Any other type: pkt_err=1, no other side effects.
- fCH_* and HB_CHlimit hold their value between updates.
- start while busy is ignored; it is neither queued nor restarts the parse. start in the done cycle is also ignored; accepted starts are back-to-back at most every 12 cycles.
- Address wrap: pkt_base near the top wraps modulo MEM_DEPTH; no error.
- rst mid-parse: immediate abort, all outputs 0 next cycle, no done pulse.
- Width rule: byte 2k is the MSB of field k.

Decomposition:
- Shared package eer_pkg: pkt_type_e enum (PKT_HB=16'h0001, PKT_CHA=16'h0002), WORD_WIDTH default, and a ch_info_t packed struct {CH_ID, CH_Hops, CH_QValue}. knownCH reuses the same struct.
- No sub-module. The FSM, byte counter and 4-word field buffer stay in one module.

Test Plan:
- CHA at base 0x010 (bytes 00 02 00 07 00 03 12 34), my_ID=1 → cycle 11: en_KCH=1, done=1, fCH_ID=7, fCH_Hops=4, fCH_QValue=0x1234.
- HB at base 0x020 (00 01 00 01 00 05 xx xx) → cycle 11: HB_reset=1, HB_CHlimit=5; fCH_* unchanged; en_KCH=0.
- CHA with ID=my_ID=9, then CHA with hops=0xFFFF → first: done only, fCH unchanged; second: fCH_Hops=0xFFFF (saturated).
- Type 0x00AB → pkt_err=1 with done; no en_KCH or HB_reset. Base 0x7FC → mem_addr sequence 7FC,7FD,7FE,7FF,000,001,002,003.
- Second start at cycle 4 of a parse → ignored; exactly one done, at cycle 11.
- rst asserted at cycle 6 → busy=0 and all outputs 0 next cycle, no done. A new start after rst parses normally with 11-cycle latency.
